// File: rtl/cam_capture_win.sv
// OV7670 byte-pair pixel capture in the pixel-clock domain: pairs bytes into
// RGB444/RGB565 pixels, optionally decimates 2x, and emits linear frame-buffer writes.
module cam_capture_win #(
    parameter int unsigned FMT      = 0,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DECIM    = 1,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              i_pclk,
    input  logic              i_rst_n,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_D,
    input  logic              i_cam_done,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [15:0]       o_pix_data,
    output logic              o_wren,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_line_err,
    output logic              o_ovf_err
);

    localparam int unsigned LINE_BYTES = 2 * H_ACTIVE;
    localparam int unsigned BC_W       = $clog2(LINE_BYTES + 2);
    localparam int unsigned PX_W       = $clog2(H_ACTIVE + 1) + 1;
    localparam int unsigned LN_W       = $clog2(V_ACTIVE + 1) + 1;
    localparam int unsigned AC_W       = ADDR_W + 1;
    localparam int unsigned MAX_PIX    = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state, next_state;
    logic            vs_r1, vs_r2;
    logic            href_d;
    logic            phase;
    logic [7:0]      hi_byte;
    logic [BC_W-1:0] byte_cnt;
    logic [PX_W-1:0] px_idx;
    logic [LN_W-1:0] line_idx;
    logic [AC_W-1:0] addr;

    logic            vs_fall_c, vs_rise_c;
    logic            start_c, end_c;
    logic            line_end_c;
    logic            keep_c, full_c;
    logic [BC_W-1:0] byte_inc_c, line_bytes_c;
    logic [15:0]     pix_c;

    assign vs_fall_c = !vs_r1 && vs_r2;
    assign vs_rise_c = vs_r1 && !vs_r2;

    // Frame sequencing: configuration gate, blanking, active frame
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        end_c      = 1'b0;
        case (state)
            ST_WAIT: if (vs_fall_c && i_cam_done) next_state = ST_IDLE;
            ST_IDLE: if (vs_fall_c) begin
                next_state = ST_DATA;
                start_c    = 1'b1;
            end
            ST_DATA: if (vs_rise_c) begin
                next_state = ST_IDLE;
                end_c      = 1'b1;
            end
            default: next_state = ST_WAIT;
        endcase
    end

    // Vsync rising while href is still high closes the line as well
    assign line_end_c   = (state == ST_DATA) && href_d && (!i_href || vs_rise_c);
    assign byte_inc_c   = (byte_cnt == '1) ? byte_cnt : byte_cnt + BC_W'(1);
    assign line_bytes_c = i_href ? byte_inc_c : byte_cnt;
    assign keep_c       = (DECIM == 1) || (!px_idx[0] && !line_idx[0]);
    assign full_c       = (addr == AC_W'(MAX_PIX));
    assign pix_c        = (FMT == 1) ? {hi_byte, i_D} : {4'b0000, hi_byte[3:0], i_D};

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_WAIT;
        else          state <= next_state;
    end

    // Byte pairing, decimation, addressing and per-frame status
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_r1        <= 1'b0;
            vs_r2        <= 1'b0;
            href_d       <= 1'b0;
            phase        <= 1'b0;
            hi_byte      <= 8'd0;
            byte_cnt     <= '0;
            px_idx       <= '0;
            line_idx     <= '0;
            addr         <= '0;
            o_pix_addr   <= '0;
            o_pix_data   <= 16'd0;
            o_wren       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= 8'd0;
            o_line_err   <= 1'b0;
            o_ovf_err    <= 1'b0;
        end else begin
            vs_r1        <= i_vsync;
            vs_r2        <= vs_r1;
            href_d       <= i_href;
            o_wren       <= 1'b0;
            o_frame_done <= 1'b0;
            if (start_c) begin
                addr       <= '0;
                byte_cnt   <= '0;
                px_idx     <= '0;
                line_idx   <= '0;
                phase      <= 1'b0;
                o_line_err <= 1'b0;
                o_ovf_err  <= 1'b0;
            end else if (state == ST_DATA) begin
                if (i_href) begin
                    byte_cnt <= byte_inc_c;
                    phase    <= ~phase;
                    if (!phase) begin
                        hi_byte <= i_D;
                    end else begin
                        px_idx <= px_idx + PX_W'(1);
                        if (keep_c) begin
                            if (full_c) begin
                                o_ovf_err <= 1'b1;
                            end else begin
                                o_wren     <= 1'b1;
                                o_pix_data <= pix_c;
                                o_pix_addr <= addr[ADDR_W-1:0];
                                addr       <= addr + AC_W'(1);
                            end
                        end
                    end
                end
                // A dangling high byte is dropped by forcing the phase back to 0
                if (line_end_c) begin
                    phase    <= 1'b0;
                    byte_cnt <= '0;
                    px_idx   <= '0;
                    line_idx <= line_idx + LN_W'(1);
                    if (line_bytes_c != BC_W'(LINE_BYTES)) o_line_err <= 1'b1;
                end
                if (end_c) begin
                    o_frame_done <= 1'b1;
                    o_frame_cnt  <= o_frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule
